// File: rtl/pc_redirect_unit_pkg.sv
// Shared encodings for the IF-stage PC redirect logic: EX NextType codes and
// the fetch-control FSM states.
package pc_redirect_unit_pkg;

    localparam logic [1:0] NT_SEQ     = 2'b00;
    localparam logic [1:0] NT_PRED_OK = 2'b01;
    localparam logic [1:0] NT_MISPRED = 2'b10;
    localparam logic [1:0] NT_JUMP    = 2'b11;

    typedef enum logic [1:0] {
        BOOT    = 2'b00,
        RUN     = 2'b01,
        RECOVER = 2'b10
    } state_e;

    // Mispredicts and jumps are the only NextTypes that steer fetch away.
    function automatic logic is_redirect_type(input logic [1:0] nt);
        return (nt == NT_MISPRED) || (nt == NT_JUMP);
    endfunction

endpackage

// File: rtl/pc_redirect_unit_sat_counter.sv
// Saturating event counter: counts up on inc and sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/pc_redirect_unit.sv
// IF-stage PC register, next-PC selector, redirect/flush control and
// redirect event counters.
module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_3000),
    parameter int               CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       next_type,
    input  logic [WIDTH-1:0] recover_pc,
    input  logic [WIDTH-1:0] jump_pc,
    input  logic             id_pred_taken,
    input  logic [WIDTH-1:0] id_pred_target,
    input  logic             stall,
    output logic [WIDTH-1:0] pc,
    output logic             if_valid,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic [CNT_W-1:0] mispred_cnt,
    output logic [CNT_W-1:0] jump_cnt,
    output logic [CNT_W-1:0] branch_cnt
);

    localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);
    localparam int               N_CNT      = 3;

    state_e           state_reg, state_next;
    logic [WIDTH-1:0] pc_reg, pc_next;
    logic             if_valid_reg;
    logic             redirect;
    logic             pred_redirect;

    assign redirect      = is_redirect_type(next_type) && (state_reg != BOOT);
    // ID-stage taken prediction only applies when ID holds a real instruction.
    assign pred_redirect = id_pred_taken && (state_reg == RUN) && !stall && !redirect;

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            BOOT:    state_next = RUN;
            RUN:     state_next = redirect ? RECOVER : RUN;
            RECOVER: state_next = redirect ? RECOVER : RUN;
            default: state_next = BOOT;
        endcase
    end

    // A redirect wins over stall: the stalled younger instructions get flushed.
    always_comb begin
        pc_next = pc_reg + WIDTH'(4);
        if (next_type == NT_JUMP) begin
            pc_next = jump_pc & ALIGN_MASK;
        end else if (next_type == NT_MISPRED) begin
            pc_next = recover_pc & ALIGN_MASK;
        end else if (stall) begin
            pc_next = pc_reg;
        end else if (id_pred_taken && (state_reg == RUN)) begin
            pc_next = id_pred_target & ALIGN_MASK;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= BOOT;
            pc_reg       <= RESET_PC;
            if_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            if_valid_reg <= !redirect;
        end
    end

    assign pc         = pc_reg;
    assign if_valid   = if_valid_reg;
    assign flush_idex = redirect && !rst;
    assign flush_ifid = (redirect || pred_redirect) && !rst;

    logic [N_CNT-1:0] cnt_inc;
    logic [CNT_W-1:0] cnt_val [N_CNT];

    assign cnt_inc[0] = (state_reg != BOOT) && (next_type == NT_MISPRED);
    assign cnt_inc[1] = (state_reg != BOOT) && (next_type == NT_JUMP);
    assign cnt_inc[2] = (state_reg != BOOT) &&
                        ((next_type == NT_PRED_OK) || (next_type == NT_MISPRED));

    generate
        for (genvar gi = 0; gi < N_CNT; gi++) begin : g_cnt
            sat_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk (clk),
                .rst (rst),
                .inc (cnt_inc[gi]),
                .cnt (cnt_val[gi])
            );
        end
    endgenerate

    assign mispred_cnt = cnt_val[0];
    assign jump_cnt    = cnt_val[1];
    assign branch_cnt  = cnt_val[2];

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit; a second instance with 2-bit counters
// shares the stimulus to exercise counter saturation.
module tb_pc_redirect_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  next_type;
    logic [31:0] recover_pc;
    logic [31:0] jump_pc;
    logic        id_pred_taken;
    logic [31:0] id_pred_target;
    logic        stall;

    logic [31:0] pc;
    logic        if_valid, flush_ifid, flush_idex;
    logic [15:0] mispred_cnt, jump_cnt, branch_cnt;

    logic [31:0] pc2;
    logic        if_valid2, flush_ifid2, flush_idex2;
    logic [1:0]  mispred_cnt2, jump_cnt2, branch_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_redirect_unit u_dut (
        .clk(clk), .rst(rst), .next_type(next_type), .recover_pc(recover_pc),
        .jump_pc(jump_pc), .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target),
        .stall(stall), .pc(pc), .if_valid(if_valid), .flush_ifid(flush_ifid),
        .flush_idex(flush_idex), .mispred_cnt(mispred_cnt), .jump_cnt(jump_cnt),
        .branch_cnt(branch_cnt)
    );

    pc_redirect_unit #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .next_type(next_type), .recover_pc(recover_pc),
        .jump_pc(jump_pc), .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target),
        .stall(stall), .pc(pc2), .if_valid(if_valid2), .flush_ifid(flush_ifid2),
        .flush_idex(flush_idex2), .mispred_cnt(mispred_cnt2), .jump_cnt(jump_cnt2),
        .branch_cnt(branch_cnt2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; next_type = 2'b00; recover_pc = '0; jump_pc = '0;
        id_pred_taken = 1'b0; id_pred_target = '0; stall = 1'b0;
        step(); step();
        checks++;
        if (pc !== 32'h3000) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, 32'h3000); end
        checks++;
        if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid: got %b want 0", if_valid); end
        checks++;
        if ({mispred_cnt, jump_cnt, branch_cnt} !== 48'd0) begin
            errors++; $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", mispred_cnt, jump_cnt, branch_cnt);
        end
        rst = 1'b0;
        step();
        checks++;
        if (pc !== 32'h3004 || if_valid !== 1'b1) begin
            errors++; $display("FAIL boot_exit: got pc=%h v=%b want pc=00003004 v=1", pc, if_valid);
        end
        $display("reset: pc=%h if_valid=%b", pc, if_valid);
    endtask

    task automatic test_mispredict();
        next_type = 2'b10; recover_pc = 32'h3024;
        #1;
        checks++;
        if (flush_ifid !== 1'b1 || flush_idex !== 1'b1) begin
            errors++; $display("FAIL mispred_flush: got ifid=%b idex=%b want 1/1", flush_ifid, flush_idex);
        end
        step();
        next_type = 2'b00;
        checks++;
        if (pc !== 32'h3024 || if_valid !== 1'b0) begin
            errors++; $display("FAIL mispred_pc: got pc=%h v=%b want pc=00003024 v=0", pc, if_valid);
        end
        checks++;
        if (mispred_cnt !== 16'd1 || branch_cnt !== 16'd1) begin
            errors++; $display("FAIL mispred_cnt: got m=%0d b=%0d want 1/1", mispred_cnt, branch_cnt);
        end
        step();
        checks++;
        if (pc !== 32'h3028 || if_valid !== 1'b1) begin
            errors++; $display("FAIL mispred_resume: got pc=%h v=%b want pc=00003028 v=1", pc, if_valid);
        end
        $display("mispredict: pc=%h mispred_cnt=%0d branch_cnt=%0d", pc, mispred_cnt, branch_cnt);
    endtask

    task automatic test_redirect_stall();
        stall = 1'b1; next_type = 2'b11; jump_pc = 32'h4002;
        #1;
        checks++;
        if (flush_ifid !== 1'b1 || flush_idex !== 1'b1) begin
            errors++; $display("FAIL jump_stall_flush: got ifid=%b idex=%b want 1/1", flush_ifid, flush_idex);
        end
        step();
        stall = 1'b0; next_type = 2'b00;
        checks++;
        if (pc !== 32'h4000 || jump_cnt !== 16'd1) begin
            errors++; $display("FAIL jump_stall_pc: got pc=%h jc=%0d want pc=00004000 jc=1", pc, jump_cnt);
        end
        step();
        $display("redirect+stall: pc=%h jump_cnt=%0d", pc, jump_cnt);
    endtask

    task automatic test_pred_taken();
        id_pred_taken = 1'b1; id_pred_target = 32'h3100;
        #1;
        checks++;
        if (flush_ifid !== 1'b1 || flush_idex !== 1'b0) begin
            errors++; $display("FAIL pred_flush: got ifid=%b idex=%b want 1/0", flush_ifid, flush_idex);
        end
        step();
        id_pred_taken = 1'b0;
        checks++;
        if (pc !== 32'h3100 || if_valid !== 1'b1) begin
            errors++; $display("FAIL pred_pc: got pc=%h v=%b want pc=00003100 v=1", pc, if_valid);
        end
        next_type = 2'b10; recover_pc = 32'h3200;
        step();
        next_type = 2'b00; id_pred_taken = 1'b1; id_pred_target = 32'h3100;
        #1;
        checks++;
        if (flush_ifid !== 1'b0 || flush_idex !== 1'b0) begin
            errors++; $display("FAIL recover_pred_flush: got ifid=%b idex=%b want 0/0", flush_ifid, flush_idex);
        end
        step();
        checks++;
        if (pc !== 32'h3204) begin errors++; $display("FAIL recover_pred_pc: got %h want 00003204", pc); end
        stall = 1'b1;
        #1;
        checks++;
        if (flush_ifid !== 1'b0) begin errors++; $display("FAIL stall_pred_flush: got %b want 0", flush_ifid); end
        step();
        checks++;
        if (pc !== 32'h3204) begin errors++; $display("FAIL stall_hold: got %h want 00003204", pc); end
        stall = 1'b0; id_pred_taken = 1'b0;
        $display("pred_taken: pc=%h mispred_cnt=%0d", pc, mispred_cnt);
    endtask

    task automatic test_wrap();
        next_type = 2'b11; jump_pc = 32'hFFFF_FFFF;
        step();
        next_type = 2'b00;
        checks++;
        if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL align_pc: got %h want fffffffc", pc); end
        step();
        checks++;
        if (pc !== 32'h0000_0000) begin errors++; $display("FAIL wrap_pc: got %h want 00000000", pc); end
        $display("wrap: pc=%h", pc);
    endtask

    task automatic test_back_to_back();
        next_type = 2'b11; jump_pc = 32'h6000;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (if_valid !== 1'b0 || pc !== 32'h6000) begin
                errors++; $display("FAIL b2b_jump%0d: got pc=%h v=%b want pc=00006000 v=0", i, pc, if_valid);
            end
            $display("b2b jump %0d: jump_cnt=%0d jump_cnt2=%0d", i, jump_cnt, jump_cnt2);
        end
        checks++;
        if (jump_cnt !== 16'd5) begin errors++; $display("FAIL jump_cnt_total: got %0d want 5", jump_cnt); end
        checks++;
        if (jump_cnt2 !== 2'd3) begin errors++; $display("FAIL jump_cnt_sat: got %0d want 3", jump_cnt2); end
        checks++;
        if (mispred_cnt !== 16'd2 || branch_cnt !== 16'd2) begin
            errors++; $display("FAIL other_cnts: got m=%0d b=%0d want 2/2", mispred_cnt, branch_cnt);
        end
    endtask

    task automatic test_async_reset();
        jump_pc = 32'h5000;
        #1;
        checks++;
        if (flush_ifid !== 1'b1 || flush_idex !== 1'b1) begin
            errors++; $display("FAIL pre_rst_flush: got ifid=%b idex=%b want 1/1", flush_ifid, flush_idex);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (pc !== 32'h3000 || flush_ifid !== 1'b0 || flush_idex !== 1'b0) begin
            errors++; $display("FAIL async_rst: got pc=%h ifid=%b idex=%b want 00003000/0/0", pc, flush_ifid, flush_idex);
        end
        checks++;
        if (jump_cnt !== 16'd0 || if_valid !== 1'b0) begin
            errors++; $display("FAIL async_rst_state: got jc=%0d v=%b want 0/0", jump_cnt, if_valid);
        end
        next_type = 2'b00;
        step();
        rst = 1'b0;
        step();
        checks++;
        if (pc !== 32'h3004 || if_valid !== 1'b1) begin
            errors++; $display("FAIL post_rst: got pc=%h v=%b want 00003004/1", pc, if_valid);
        end
        $display("async reset: pc=%h if_valid=%b", pc, if_valid);
    endtask

    initial begin
        test_reset();
        test_mispredict();
        test_redirect_stall();
        test_pred_taken();
        test_wrap();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
